fetch_trigger_responder: RTL and testbench

- Consumes the seven one-hot fetch strobes produced by the fetch trigger sequencer and performs the work each strobe requests:
  - latches the branch request
  - updates the PC
  - drives program-memory reads
  - assembles a two-byte instruction
  - presents it on an output latch
- Also checks protocol order and reports violations.
- Sits between the fetch sequencer and the program memory / execute stage.

---
 rtl/fetch_trigger_responder.sv | 162 ++++++++++++++++
 tb/tb_fetch_trigger_responder.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_trigger_responder.sv
// Executes the seven one-hot fetch strobes: branch latch, PC update, two program-memory
// reads and instruction publication, with protocol-order checking. Optional macro: CTRL_CHECK_EN.
module fetch_trigger_responder #(
    parameter int unsigned PC_WIDTH      = 8,
    parameter int unsigned BYTE_WIDTH    = 8,
    parameter int unsigned ERR_CNT_WIDTH = 4
) (
    input  logic                    clock,
    input  logic                    n_reset,
    input  logic                    latch_trigger,
    input  logic                    update_pc_trigger,
    input  logic                    fetch_mem1_trigger,
    input  logic                    decode_instr1_trigger,
    input  logic                    fetch_mem2_trigger,
    input  logic                    decode_instr2_trigger,
    input  logic                    out_latch_trigger,
    input  logic                    mem_mux_control,
    input  logic                    demux_control,
    input  logic                    jump_req,
    input  logic [PC_WIDTH-1:0]     jump_addr,
    output logic                    prog_mem_rd,
    output logic [PC_WIDTH-1:0]     prog_mem_addr,
    input  logic [BYTE_WIDTH-1:0]   prog_mem_data,
    output logic [PC_WIDTH-1:0]     pc,
    output logic [2*BYTE_WIDTH-1:0] instr_out,
    output logic                    instr_valid,
    output logic                    seq_error,
    output logic [ERR_CNT_WIDTH-1:0] err_count
);

    localparam int unsigned NUM_STEPS = 7;

    typedef enum logic [2:0] {
        EXP_LATCH = 3'd0,
        EXP_UPC   = 3'd1,
        EXP_F1    = 3'd2,
        EXP_D1    = 3'd3,
        EXP_F2    = 3'd4,
        EXP_D2    = 3'd5,
        EXP_OUT   = 3'd6
    } state_t;

    state_t state, next_state;

    logic [NUM_STEPS-1:0]  strobes;
    logic [NUM_STEPS-1:0]  exp_strobe;
    logic                  matched;
    logic                  violation;
    logic                  ctrl_err;
    logic                  err_inc;
    logic                  do_latch;
    logic                  do_upc;
    logic                  do_d1;
    logic                  do_d2;
    logic                  do_out;
    logic [BYTE_WIDTH-1:0] first_byte;
    logic [BYTE_WIDTH-1:0] second_byte;
    logic                  jump_pend;
    logic [PC_WIDTH-1:0]   jump_tgt;

    assign strobes = {out_latch_trigger, decode_instr2_trigger, fetch_mem2_trigger,
                      decode_instr1_trigger, fetch_mem1_trigger, update_pc_trigger,
                      latch_trigger};

    // A cycle matches only when the sole high strobe is the one the state expects
    always_comb begin
        exp_strobe = NUM_STEPS'(1) << state;
        matched    = (strobes == exp_strobe);
        violation  = (|strobes) && !matched;
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state <= EXP_LATCH;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (matched) begin
            case (state)
                EXP_LATCH: next_state = EXP_UPC;
                EXP_UPC:   next_state = EXP_F1;
                EXP_F1:    next_state = EXP_D1;
                EXP_D1:    next_state = EXP_F2;
                EXP_F2:    next_state = EXP_D2;
                EXP_D2:    next_state = EXP_OUT;
                default:   next_state = EXP_LATCH;
            endcase
        end else if (violation) begin
            // A latch strobe inside a bad cycle resynchronises the sequence
            next_state = latch_trigger ? EXP_UPC : EXP_LATCH;
        end
    end

    always_comb begin
        do_latch      = (matched && state == EXP_LATCH) || (violation && latch_trigger);
        do_upc        = matched && (state == EXP_UPC);
        do_d1         = matched && (state == EXP_D1);
        do_d2         = matched && (state == EXP_D2);
        do_out        = matched && (state == EXP_OUT);
        prog_mem_rd   = matched && (state == EXP_F1 || state == EXP_F2);
        prog_mem_addr = (matched && state == EXP_F2) ? pc + PC_WIDTH'(1) : pc;
    end

`ifdef CTRL_CHECK_EN
    // Sequencer mux/demux levels must track the step being executed
    always_comb begin
        ctrl_err = matched &&
                   ((mem_mux_control != (state == EXP_D1 || state == EXP_F2)) ||
                    (demux_control   != (state == EXP_D2 || state == EXP_OUT)));
    end
`else
    logic ctrl_unused;
    assign ctrl_unused = &{1'b0, mem_mux_control, demux_control};
    assign ctrl_err    = 1'b0;
`endif

    assign err_inc = violation || ctrl_err;

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            pc          <= '0;
            instr_out   <= '0;
            instr_valid <= 1'b0;
            seq_error   <= 1'b0;
            err_count   <= '0;
            first_byte  <= '0;
            second_byte <= '0;
            jump_pend   <= 1'b0;
            jump_tgt    <= '0;
        end else begin
            instr_valid <= do_out;
            if (do_latch) begin
                jump_pend <= jump_req;
                jump_tgt  <= jump_addr;
            end
            if (do_upc) begin
                pc        <= jump_pend ? jump_tgt : pc + PC_WIDTH'(2);
                jump_pend <= 1'b0;
            end
            if (do_d1) begin
                first_byte <= prog_mem_data;
            end
            if (do_d2) begin
                second_byte <= prog_mem_data;
            end
            if (do_out) begin
                instr_out <= {first_byte, second_byte};
            end
            if (err_inc) begin
                seq_error <= 1'b1;
                if (err_count != {ERR_CNT_WIDTH{1'b1}}) begin
                    err_count <= err_count + ERR_CNT_WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_trigger_responder.sv
// Scoreboard bench for fetch_trigger_responder: a step-rule reference model predicts
// memory reads and published instructions; a negedge monitor checks them as they appear.
module tb_fetch_trigger_responder;

    localparam int unsigned PW = 8;
    localparam int unsigned BW = 8;
    localparam int unsigned EW = 4;

    logic          clock;
    logic          n_reset;
    logic          latch_trigger, update_pc_trigger, fetch_mem1_trigger, decode_instr1_trigger;
    logic          fetch_mem2_trigger, decode_instr2_trigger, out_latch_trigger;
    logic          mem_mux_control, demux_control;
    logic          jump_req;
    logic [PW-1:0] jump_addr;
    logic          prog_mem_rd;
    logic [PW-1:0] prog_mem_addr;
    logic [BW-1:0] prog_mem_data;
    logic [PW-1:0] pc;
    logic [2*BW-1:0] instr_out;
    logic          instr_valid;
    logic          seq_error;
    logic [EW-1:0] err_count;

    fetch_trigger_responder #(.PC_WIDTH(PW), .BYTE_WIDTH(BW), .ERR_CNT_WIDTH(EW)) dut (
        .clock(clock), .n_reset(n_reset),
        .latch_trigger(latch_trigger), .update_pc_trigger(update_pc_trigger),
        .fetch_mem1_trigger(fetch_mem1_trigger), .decode_instr1_trigger(decode_instr1_trigger),
        .fetch_mem2_trigger(fetch_mem2_trigger), .decode_instr2_trigger(decode_instr2_trigger),
        .out_latch_trigger(out_latch_trigger),
        .mem_mux_control(mem_mux_control), .demux_control(demux_control),
        .jump_req(jump_req), .jump_addr(jump_addr),
        .prog_mem_rd(prog_mem_rd), .prog_mem_addr(prog_mem_addr), .prog_mem_data(prog_mem_data),
        .pc(pc), .instr_out(instr_out), .instr_valid(instr_valid),
        .seq_error(seq_error), .err_count(err_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Program memory: data appears the cycle after a read strobe and holds
    logic [BW-1:0] mem [256];
    logic [BW-1:0] mem_q;
    assign prog_mem_data = mem_q;
    always @(posedge clock) if (prog_mem_rd) mem_q <= mem[prog_mem_addr];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    int m_step, m_pc, m_jt, m_first, m_second, m_errcnt, m_rdata;
    bit m_jp, m_seqerr;
    bit bad_mux;
    int rd_q[$];
    int out_q[$];

    task automatic check(string name, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_step = 0; m_pc = 0; m_jt = 0; m_first = 0; m_second = 0;
        m_errcnt = 0; m_rdata = 0; m_jp = 0; m_seqerr = 0;
        rd_q.delete();
        out_q.delete();
    endtask

    task automatic model_err();
        m_seqerr = 1;
        if (m_errcnt < 15) m_errcnt++;
    endtask

    task automatic model_read(int a);
        rd_q.push_back(a);
        m_rdata = int'(mem[a]);
    endtask

    // One clock of behaviour, expressed as the step rules
    task automatic model_cycle(bit [6:0] s, bit jr, int ja, bit mux, bit dmx);
        int n;
        n = $countones(s);
        if (n == 0) return;
        if (n == 1 && s[m_step]) begin
`ifdef CTRL_CHECK_EN
            if (mux != (m_step == 3 || m_step == 4) || dmx != (m_step == 5 || m_step == 6))
                model_err();
`endif
            case (m_step)
                0: begin m_jp = jr; m_jt = ja; end
                1: begin m_pc = m_jp ? m_jt : (m_pc + 2) % 256; m_jp = 0; end
                2: model_read(m_pc);
                3: m_first = m_rdata;
                4: model_read((m_pc + 1) % 256);
                5: m_second = m_rdata;
                default: out_q.push_back(((m_first * 256 + m_second) << 8) | m_pc);
            endcase
            m_step = (m_step + 1) % 7;
        end else begin
            model_err();
            if (s[0]) begin
                m_jp = jr; m_jt = ja; m_step = 1;
            end else begin
                m_step = 0;
            end
        end
    endtask

    task automatic drive(bit [6:0] s, bit jr, bit [7:0] ja, bit mux, bit dmx);
        {out_latch_trigger, decode_instr2_trigger, fetch_mem2_trigger, decode_instr1_trigger,
         fetch_mem1_trigger, update_pc_trigger, latch_trigger} = s;
        jump_req = jr; jump_addr = ja;
        mem_mux_control = mux; demux_control = dmx;
    endtask

    task automatic cycle(bit [6:0] s, bit jr, bit [7:0] ja);
        bit mux, dmx;
        mux = (m_step == 3 || m_step == 4) && !bad_mux;
        dmx = (m_step == 5 || m_step == 6);
        drive(s, jr, ja, mux, dmx);
        model_cycle(s, jr, int'(ja), mux, dmx);
        @(posedge clock);
        #1;
        check("pc", int'(pc), m_pc);
        check("seq_error", int'(seq_error), int'(m_seqerr));
        check("err_count", int'(err_count), m_errcnt);
    endtask

    task automatic run_loop(int jr_step, bit [7:0] ja, bit gaps);
        for (int st = 0; st < 7; st++) begin
            if (gaps) repeat ($urandom_range(0, 2)) cycle(7'd0, 1'b0, 8'd0);
            cycle(7'(1) << st, st == jr_step, ja);
        end
    endtask

    // Monitor: pop the scoreboard whenever the DUT presents a read or an instruction
    always @(negedge clock) begin
        if (n_reset) begin
            if (prog_mem_rd) begin
                if (rd_q.size() == 0) check("unexpected_read", int'(prog_mem_addr), -1);
                else check("read_addr", int'(prog_mem_addr), rd_q.pop_front());
            end
            if (instr_valid) begin
                if (out_q.size() == 0) begin
                    check("unexpected_valid", int'(instr_out), -1);
                end else begin
                    int v;
                    v = out_q.pop_front();
                    check("instr_out", int'(instr_out), v >> 8);
                    check("pc_at_valid", int'(pc), v & 255);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = BW'($urandom);
        mem[0] = 8'hA1; mem[1] = 8'hB2;
        mem_q = '0;
        bad_mux = 1'b0;
        drive(7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        model_reset();
        n_reset = 1'b1;
        #2 n_reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_pc", int'(pc), 0);
        check("rst_instr_out", int'(instr_out), 0);
        check("rst_instr_valid", int'(instr_valid), 0);
        check("rst_seq_error", int'(seq_error), 0);
        check("rst_err_count", int'(err_count), 0);
        @(negedge clock) n_reset = 1'b1;
        @(posedge clock);
        #1;

        // Clean loop jumping to 0: fetch 0/1, publish 0xA1B2
        run_loop(0, 8'h00, 1'b0);
        cycle(7'd0, 1'b0, 8'd0);
        check("first_instr", int'(instr_out), 16'hA1B2);
        run_loop(-1, 8'h00, 1'b0);
        check("pc_plus2", int'(pc), 2);

        // Branch at step 0, then a request at step 3 is ignored
        run_loop(0, 8'h40, 1'b0);
        check("pc_jump", int'(pc), 8'h40);
        run_loop(3, 8'h10, 1'b0);
        check("pc_ignored_jump", int'(pc), 8'h42);

        // Wrap: 0xFE advances to 0x00; from 0xFF the second fetch wraps to 0x00
        run_loop(0, 8'hFE, 1'b0);
        run_loop(-1, 8'h00, 1'b0);
        check("pc_wrap", int'(pc), 0);
        run_loop(0, 8'hFF, 1'b0);

        // Skip decode step 3
        cycle(7'h01, 1'b0, 8'd0);
        cycle(7'h02, 1'b0, 8'd0);
        cycle(7'h04, 1'b0, 8'd0);
        cycle(7'h10, 1'b0, 8'd0);
        check("skip_err_count", int'(err_count), 1);
        run_loop(-1, 8'h00, 1'b0);
        cycle(7'd0, 1'b0, 8'd0);
        check("skip_sticky", int'(seq_error), 1);

        // Double strobes saturate the error counter
        for (int i = 0; i < 20; i++) begin
            int a, b;
            a = $urandom_range(0, 6);
            b = (a + $urandom_range(1, 6)) % 7;
            cycle((7'(1) << a) | (7'(1) << b), 1'($urandom), 8'($urandom));
        end
        check("err_saturate", int'(err_count), 15);

        run_loop(-1, 8'h00, 1'b1);
        run_loop(0, 8'h80, 1'b1);
        cycle(7'd0, 1'b0, 8'd0);

        // Asynchronous reset while the second fetch strobe is high
        for (int st = 0; st < 4; st++) cycle(7'(1) << st, 1'b0, 8'd0);
        drive(7'h10, 1'b0, 8'd0, 1'b1, 1'b0);
        #1 n_reset = 1'b0;
        #1;
        check("mid_rst_pc", int'(pc), 0);
        check("mid_rst_instr", int'(instr_out), 0);
        check("mid_rst_valid", int'(instr_valid), 0);
        check("mid_rst_seq_error", int'(seq_error), 0);
        check("mid_rst_err_count", int'(err_count), 0);
        check("mid_rst_rd", int'(prog_mem_rd), 0);
        drive(7'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        model_reset();
        @(negedge clock) n_reset = 1'b1;
        @(posedge clock);
        #1;

        // Wrong mux level at step 3: flagged only when control checking is built in
        for (int st = 0; st < 7; st++) begin
            bad_mux = (st == 3);
            cycle(7'(1) << st, 1'b0, 8'd0);
        end
        bad_mux = 1'b0;
        cycle(7'd0, 1'b0, 8'd0);
        check("ctrl_seq_error", int'(seq_error), int'(m_seqerr));

        // Randomised traffic biased towards legal sequences
        for (int i = 0; i < 400; i++) begin
            int r;
            bit [6:0] s;
            r = $urandom_range(0, 99);
            if (r < 75)      s = 7'(1) << m_step;
            else if (r < 87) s = 7'd0;
            else             s = 7'($urandom);
            cycle(s, 1'($urandom), 8'($urandom));
        end

        repeat (3) cycle(7'd0, 1'b0, 8'd0);
        check("reads_drained", rd_q.size(), 0);
        check("instrs_drained", out_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
